// File: rtl/reg_file_param.sv
// Parameterised register file: 2 async read ports, 1 sync write port, optional
// write-to-read bypass, optional hardwired zero register, sequenced soft clear.

module reg_file_entry #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  // Clear and write never overlap (writes are dropped during the sweep).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     q <= '0;
    else if (clr)   q <= '0;
    else if (wr_en) q <= d;
  end
endmodule

module reg_file_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AW       = $clog2(DEPTH),
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [WIDTH-1:0]        IN,
  input  logic [AW-1:0]           INADDRESS,
  input  logic                    WRITE,
  input  logic [AW-1:0]           OUT1ADDRESS,
  input  logic [AW-1:0]           OUT2ADDRESS,
  output logic signed [WIDTH-1:0] OUT1,
  output logic signed [WIDTH-1:0] OUT2,
  input  logic                    CLEAR,
  output logic                    BUSY,
  output logic                    WRITE_DROP
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SWEEP = 1'b1;

  logic [0:0]                  state;
  logic [AW-1:0]               idx;
  logic                        busy;
  logic                        wr_zero;
  logic                        wr_ok;
  logic [DEPTH-1:0][WIDTH-1:0] regs;

  assign busy    = (state == SWEEP);
  assign BUSY    = busy;
  assign wr_zero = (ZERO_REG != 0) && (INADDRESS == '0);
  assign wr_ok   = WRITE && !busy && !wr_zero;

  // Index wraps to 0 naturally on the last sweep edge since DEPTH is a power of two.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      idx        <= '0;
      WRITE_DROP <= 1'b0;
    end else begin
      WRITE_DROP <= busy && WRITE && !wr_zero;
      case (state)
        IDLE: begin
          if (CLEAR) begin
            state <= SWEEP;
            idx   <= '0;
          end
        end
        SWEEP: begin
          idx <= idx + AW'(1);
          if (idx == AW'(DEPTH - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    if (ZERO_REG != 0 && i == 0) begin : g_zero
      assign regs[i] = '0;
    end else begin : g_reg
      reg_file_entry #(.WIDTH(WIDTH)) u_ent (
        .clk   (CLK),
        .rst_n (RESET),
        .wr_en (wr_ok && (INADDRESS == AW'(i))),
        .clr   (busy && (idx == AW'(i))),
        .d     (IN),
        .q     (regs[i])
      );
    end
  end

  // wr_ok already excludes BUSY and the zero register, so it doubles as the bypass qualifier.
  always_comb begin
    OUT1 = regs[OUT1ADDRESS];
    OUT2 = regs[OUT2ADDRESS];
    if (BYPASS != 0 && wr_ok && INADDRESS == OUT1ADDRESS) OUT1 = IN;
    if (BYPASS != 0 && wr_ok && INADDRESS == OUT2ADDRESS) OUT2 = IN;
  end
endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: no-bypass, bypass and zero-register/16-bit
// instances side by side, with hand-computed expected values.

module tb_reg_file_param;
  logic       clk;
  logic       rst_n;
  logic [7:0] in8;
  logic [2:0] wa8, ra1_8, ra2_8;
  logic       we8, clr8;
  logic [7:0] nb_o1, nb_o2, by_o1, by_o2;
  logic       nb_busy, nb_drop, by_busy, by_drop;

  logic [15:0] in16;
  logic [3:0]  wa16, ra1_16, ra2_16;
  logic        we16, clr16;
  logic [15:0] zr_o1, zr_o2;
  logic        zr_busy, zr_drop;

  int checks = 0;
  int failures = 0;

  reg_file_param #(.WIDTH(8), .DEPTH(8), .BYPASS(0), .ZERO_REG(0)) u_nb (
    .CLK(clk), .RESET(rst_n), .IN(in8), .INADDRESS(wa8), .WRITE(we8),
    .OUT1ADDRESS(ra1_8), .OUT2ADDRESS(ra2_8), .OUT1(nb_o1), .OUT2(nb_o2),
    .CLEAR(clr8), .BUSY(nb_busy), .WRITE_DROP(nb_drop));

  reg_file_param #(.WIDTH(8), .DEPTH(8), .BYPASS(1), .ZERO_REG(0)) u_by (
    .CLK(clk), .RESET(rst_n), .IN(in8), .INADDRESS(wa8), .WRITE(we8),
    .OUT1ADDRESS(ra1_8), .OUT2ADDRESS(ra2_8), .OUT1(by_o1), .OUT2(by_o2),
    .CLEAR(clr8), .BUSY(by_busy), .WRITE_DROP(by_drop));

  reg_file_param #(.WIDTH(16), .DEPTH(16), .BYPASS(1), .ZERO_REG(1)) u_zr (
    .CLK(clk), .RESET(rst_n), .IN(in16), .INADDRESS(wa16), .WRITE(we16),
    .OUT1ADDRESS(ra1_16), .OUT2ADDRESS(ra2_16), .OUT1(zr_o1), .OUT2(zr_o2),
    .CLEAR(clr16), .BUSY(zr_busy), .WRITE_DROP(zr_drop));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts BUSY-high samples after each edge until it falls, bounded.
  task automatic count_busy(output int n, output logic fell);
    n = nb_busy ? 1 : 0;
    fell = 1'b0;
    for (int k = 0; k < 20 && !fell; k++) begin
      step();
      if (nb_busy) n++;
      else fell = 1'b1;
    end
  endtask

  int   bcnt;
  logic bfell;

  initial begin
    rst_n = 1'b1;
    in8 = '0; wa8 = '0; ra1_8 = '0; ra2_8 = '0; we8 = 1'b0; clr8 = 1'b0;
    in16 = '0; wa16 = '0; ra1_16 = '0; ra2_16 = '0; we16 = 1'b0; clr16 = 1'b0;

    // reset with arbitrary inputs applied
    #2 rst_n = 1'b0;
    we8 = 1'b1; in8 = 8'h77; wa8 = 3'd3; ra1_8 = 3'd5; ra2_8 = 3'd7; clr8 = 1'b1;
    we16 = 1'b1; in16 = 16'hBEEF; wa16 = 4'd4; ra1_16 = 4'd9; ra2_16 = 4'd0; clr16 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_nb_o1", 16'(nb_o1), 16'h0);
    check("rst_nb_o2", 16'(nb_o2), 16'h0);
    check("rst_by_o1", 16'(by_o1), 16'h0);
    check("rst_busy", 16'(nb_busy), 16'h0);
    check("rst_drop", 16'(nb_drop), 16'h0);
    check("rst_zr_busy", 16'(zr_busy), 16'h0);
    check("rst_zr_o1", zr_o1, 16'h0);
    we8 = 1'b0; clr8 = 1'b0; we16 = 1'b0; clr16 = 1'b0;
    #5 rst_n = 1'b1;
    step();

    // write/read, old value visible during the write cycle
    we8 = 1'b1; wa8 = 3'd3; in8 = 8'h5A; ra1_8 = 3'd3; ra2_8 = 3'd7;
    #1;
    check("nb_wr_old", 16'(nb_o1), 16'h0);
    check("by_wr_byp", 16'(by_o1), 16'h5A);
    step();
    wa8 = 3'd7; in8 = 8'hA5;
    #1;
    check("nb_r3", 16'(nb_o1), 16'h5A);
    check("nb_r7_old", 16'(nb_o2), 16'h0);
    check("by_r7_byp", 16'(by_o2), 16'hA5);
    step();
    we8 = 1'b0;
    #1;
    check("nb_r3_hold", 16'(nb_o1), 16'h5A);
    check("nb_r7", 16'(nb_o2), 16'hA5);

    // bypass on both ports at the same address
    we8 = 1'b1; wa8 = 3'd2; in8 = 8'h3C; ra1_8 = 3'd2; ra2_8 = 3'd2;
    #1;
    check("byp_o1", 16'(by_o1), 16'h3C);
    check("byp_o2", 16'(by_o2), 16'h3C);
    check("nobyp_o1", 16'(nb_o1), 16'h0);
    step();
    we8 = 1'b0;
    #1;
    check("nb_r2_stored", 16'(nb_o2), 16'h3C);

    // preload 1..8 then soft clear
    for (int i = 0; i < 8; i++) begin
      we8 = 1'b1; wa8 = 3'(i); in8 = 8'(i + 1);
      step();
    end
    we8 = 1'b0; clr8 = 1'b1;
    #1;
    check("pre_clr_busy", 16'(nb_busy), 16'h0);
    step();
    clr8 = 1'b0;
    bcnt = nb_busy ? 1 : 0;
    bfell = 1'b0;
    for (int k = 1; k <= 20 && !bfell; k++) begin
      step();
      if (k == 1) begin
        we8 = 1'b1; wa8 = 3'd6; in8 = 8'hFF; ra1_8 = 3'd6;
        #1;
        check("no_byp_busy", 16'(by_o1), 16'h07);
      end
      if (k == 2) begin
        check("drop_hi", 16'(nb_drop), 16'h1);
        we8 = 1'b0;
      end
      if (k == 3) check("drop_lo", 16'(nb_drop), 16'h0);
      if (k == 4) begin
        for (int j = 0; j < 4; j++) begin
          ra1_8 = 3'(j); ra2_8 = 3'(j + 4);
          #1;
          check("mid_lo", 16'(nb_o1), 16'h0);
          check("mid_hi", 16'(nb_o2), 16'(j + 5));
        end
      end
      if (k == 5) clr8 = 1'b1;
      if (k == 6) clr8 = 1'b0;
      if (nb_busy) bcnt++;
      else bfell = 1'b1;
    end
    check("busy_fell", 16'(bfell), 16'h1);
    check("busy_cycles", 16'(bcnt), 16'd8);
    for (int j = 0; j < 4; j++) begin
      ra1_8 = 3'(j); ra2_8 = 3'(j + 4);
      #1;
      check("end_lo", 16'(nb_o1), 16'h0);
      check("end_hi", 16'(nb_o2), 16'h0);
    end

    // reset mid-sweep
    we8 = 1'b1; wa8 = 3'd5; in8 = 8'h42;
    step();
    we8 = 1'b0; clr8 = 1'b1;
    step();
    clr8 = 1'b0;
    check("restart_busy", 16'(nb_busy), 16'h1);
    repeat (3) step();
    ra1_8 = 3'd5; ra2_8 = 3'd0;
    #1;
    check("pre_abort_r5", 16'(nb_o1), 16'h42);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 16'(nb_busy), 16'h0);
    check("abort_r5", 16'(nb_o1), 16'h0);
    #3 rst_n = 1'b1;
    clr8 = 1'b1;
    step();
    clr8 = 1'b0;
    count_busy(bcnt, bfell);
    check("resweep_fell", 16'(bfell), 16'h1);
    check("resweep_cycles", 16'(bcnt), 16'd8);

    // zero register, 16-bit, 16-deep
    we16 = 1'b1; wa16 = 4'd0; in16 = 16'h1234; ra1_16 = 4'd0; ra2_16 = 4'd15;
    #1;
    check("zr_no_byp", zr_o1, 16'h0);
    step();
    wa16 = 4'd15;
    #1;
    check("zr_r0", zr_o1, 16'h0);
    check("zr_drop0", 16'(zr_drop), 16'h0);
    step();
    we16 = 1'b0;
    #1;
    check("zr_r15", zr_o2, 16'h1234);
    check("zr_r0_after", zr_o1, 16'h0);
    check("zr_drop1", 16'(zr_drop), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_file_param.md
# reg_file_param

Parametrised successor to the CPU's 8x8 register file. It provides a DEPTH x WIDTH register array with two asynchronous read ports and one synchronous write port, plus three additions:
- an optional same-cycle write-to-read bypass,
- an optional hardwired zero register,
- a sequenced soft-clear engine that zeroes the array one entry per cycle under a BUSY handshake.

It sits between the instruction decoder/ALU writeback and the ALU operand inputs.

## Interface
Parameters:
- WIDTH, 8, data width in bits
- DEPTH, 8, number of registers; power of two, at least 2
- AW, $clog2(DEPTH), address width (derived; not overridden)
- BYPASS, 1, 1 = read ports see same-cycle write data on address match
- ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes

Ports:
- CLK  in  1  clock; all state updates on posedge
- RESET  in  1  asynchronous, active-low reset
- IN  in  WIDTH  write data
- INADDRESS  in  AW  write address
- WRITE  in  1  write enable
- OUT1ADDRESS  in  AW  read port 1 address
- OUT2ADDRESS  in  AW  read port 2 address
- OUT1  out  WIDTH  read port 1 data, signed
- OUT2  out  WIDTH  read port 2 data, signed
- CLEAR  in  1  soft-clear request, sampled on posedge
- BUSY  out  1  high while the soft-clear sweep is in progress
- WRITE_DROP  out  1  one-cycle pulse when a write is discarded because of BUSY

## Operation
- Reset (RESET=0, asynchronous): all registers 0; FSM in IDLE; sweep index 0; BUSY=0; WRITE_DROP=0. OUT1 and OUT2 therefore read 0.
- FSM states: IDLE and SWEEP.
  - IDLE -> SWEEP on posedge with CLEAR=1. The sweep index loads 0 and BUSY rises on that edge.
  - In SWEEP, each posedge writes 0 to register[index] and increments index.
  - On the edge that clears index DEPTH-1, the FSM returns to IDLE, index wraps to 0, and BUSY falls.
- CLEAR while in SWEEP is ignored; the sweep does not restart.
- Writes:
  - In IDLE with WRITE=1, the posedge stores IN into register[INADDRESS].
  - In SWEEP with WRITE=1, the write is discarded and WRITE_DROP=1 for the following cycle.
  - WRITE and CLEAR on the same IDLE edge: the write completes on that edge, then the sweep starts. The sweep later zeroes that register.
- ZERO_REG=1: register 0 is held at 0. A write to address 0 is silently ignored and does not set WRITE_DROP. Reads of address 0 return 0.
- Reads are combinational on the address and array contents:
  - OUTn = register[OUTnADDRESS].
  - When BYPASS=1, BUSY=0, WRITE=1, INADDRESS==OUTnADDRESS, and the target is not the zero register, OUTn = IN.
  - Both ports may read the same address; both then return the same value.
- During SWEEP, reads return current contents: 0 for indices below the sweep index, old values otherwise.
- No arithmetic beyond the index increment. Data is stored and returned unmodified, signed WIDTH bits.

## Timing
- Write latency: 1 cycle. The data is visible on a non-bypassed read after the posedge.
- Bypass latency: 0 cycles (combinational from IN).
- Soft clear takes exactly DEPTH cycles from the first SWEEP edge to BUSY=0.
  - BUSY is high for DEPTH cycles.
  - A new CLEAR is accepted on the first edge after BUSY falls.
- WRITE_DROP is registered: high for exactly one cycle after each dropped-write edge. Consecutive drops hold it high.
- RESET asserted mid-sweep aborts immediately: registers 0, IDLE, BUSY=0. Release is synchronised by the clock domain owner. The first edge after release behaves as IDLE.
- Simultaneous WRITE and a read of the same address with BYPASS=0: the read shows the old value until the posedge.

## Test plan
- Reset: drive RESET=0 with arbitrary inputs. All reads return 0, BUSY=0, WRITE_DROP=0.
- Write/read, BYPASS=0: write 8'h5A to r3, then 8'hA5 to r7. Read r3/r7 on OUT1/OUT2 and get 8'h5A/8'hA5, each 1 cycle after its write. During the write cycle, OUT1 at r3 shows the old value 0.
- Bypass, BYPASS=1: WRITE=1, IN=8'h3C, INADDRESS=OUT1ADDRESS=OUT2ADDRESS=2. OUT1=OUT2=8'h3C in the same cycle.
- Soft clear with DEPTH=8: preload r0..r7 with 1..8, then pulse CLEAR.
  - BUSY is high for exactly 8 cycles.
  - After 4 SWEEP edges, r0..r3 read 0 and r4..r7 read 5..8.
  - A WRITE of 8'hFF to r6 at cycle 2 is dropped and WRITE_DROP pulses for one cycle.
  - At the end, all registers read 0.
- ZERO_REG=1 and WIDTH=16, DEPTH=16: a write of 16'h1234 to r0 is ignored, r0 reads 0, and WRITE_DROP stays 0. A write to r15 reads back 16'h1234.
- Reset mid-sweep: assert RESET=0 during cycle 3 of a sweep. BUSY drops asynchronously and all registers read 0. After release, CLEAR restarts a full 8-cycle sweep.
